// File: rtl/sff_bank_readback.sv
// Flop bank (sync set/clear/CE) with MSB-first serial readback over valid/ready.
// Optional macro SFF_READBACK_PARITY_EN appends an even-parity bit to each frame.
module sff_bank_readback #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic             SSET,
    input  logic             SCLR,
    output logic [WIDTH-1:0] O,
    input  logic             CAP,
    output logic             RB_O,
    output logic             RB_VALID,
    input  logic             RB_READY,
    output logic             RB_LAST,
    output logic             BUSY,
    output logic             CAP_DROP
);

`ifdef SFF_READBACK_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] bank;
    logic [FL-1:0]    shadow;
    logic [FL-1:0]    cap_word;
    logic [CW-1:0]    count;
    logic             cap_drop;
    logic             busy;

`ifdef SFF_READBACK_PARITY_EN
    // parity is taken from the same pre-update bank value as the data bits
    assign cap_word = {bank, ^bank};
`else
    assign cap_word = bank;
`endif

    assign busy     = (state == SHIFT);
    assign O        = bank;
    assign BUSY     = busy;
    assign RB_VALID = busy;
    assign RB_O     = busy & shadow[FL-1];
    assign RB_LAST  = busy && (count == LAST_IDX);
    assign CAP_DROP = cap_drop;

    // bank update: SCLR over SSET over CE load, otherwise hold
    always_ff @(posedge CLK) begin
        if (SRST) begin
            bank <= INIT;
        end else if (SCLR) begin
            bank <= '0;
        end else if (SSET) begin
            bank <= '1;
        end else if (CE) begin
            bank <= I;
        end
    end

    // capture/shift FSM; shadow is isolated from later bank writes
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state    <= IDLE;
            shadow   <= '0;
            count    <= '0;
            cap_drop <= 1'b0;
        end else begin
            cap_drop <= CAP && busy;
            case (state)
                IDLE: begin
                    if (CAP) begin
                        shadow <= cap_word;
                        count  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (RB_READY) begin
                        shadow <= {shadow[FL-2:0], 1'b0};
                        count  <= count + CW'(1);
                        if (count == LAST_IDX) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sff_bank_readback.sv
// Randomized and directed bench for sff_bank_readback against a queue model.
// Honours SFF_READBACK_PARITY_EN for frame length and expected frames.
module tb_sff_bank_readback;

    localparam int         W     = 8;
    localparam logic [7:0] INITV = 8'hA5;
`ifdef SFF_READBACK_PARITY_EN
    localparam int          FL     = W + 1;
    localparam logic [15:0] FR_3C  = 16'h0078;
    localparam logic [15:0] FR_81  = 16'h0102;
    localparam logic [15:0] FR_07  = 16'h000F;
`else
    localparam int          FL     = W;
    localparam logic [15:0] FR_3C  = 16'h003C;
    localparam logic [15:0] FR_81  = 16'h0081;
    localparam logic [15:0] FR_07  = 16'h0007;
`endif

    logic       clk = 1'b0;
    logic       srst = 1'b0, ce = 1'b0, sset = 1'b0, sclr = 1'b0;
    logic       cap = 1'b0, ready = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] o;
    logic       rb_o, rb_valid, rb_last, busy, cap_drop;

    always #5 clk = ~clk;

    sff_bank_readback #(.WIDTH(W), .INIT(INITV)) dut (
        .CLK(clk), .SRST(srst), .CE(ce), .I(din), .SSET(sset),
        .SCLR(sclr), .O(o), .CAP(cap), .RB_O(rb_o),
        .RB_VALID(rb_valid), .RB_READY(ready), .RB_LAST(rb_last),
        .BUSY(busy), .CAP_DROP(cap_drop)
    );

    int checks = 0;
    int failures = 0;

    // model: bank value plus queue of bits still to be sent
    logic [7:0]  m_o;
    bit          q[$];
    logic        m_drop;

    logic [15:0] rx;
    int          nrx, nlast, ndrop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [7:0] old;
        if (rb_valid === 1'b1 && ready) begin
            rx = {rx[14:0], rb_o};
            nrx++;
            if (rb_last === 1'b1) nlast++;
        end
        if (srst) begin
            m_o = INITV;
            q.delete();
            m_drop = 1'b0;
        end else begin
            old = m_o;
            if (sclr) m_o = 8'h00;
            else if (sset) m_o = 8'hFF;
            else if (ce) m_o = din;
            m_drop = (q.size() > 0) && cap;
            if (q.size() > 0) begin
                if (ready) void'(q.pop_front());
            end else if (cap) begin
                for (int k = W - 1; k >= 0; k--) q.push_back(old[k]);
`ifdef SFF_READBACK_PARITY_EN
                q.push_back(^old);
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("o", 32'(o), 32'(m_o));
        chk("rb_valid", 32'(rb_valid), 32'(q.size() > 0));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("rb_last", 32'(rb_last), 32'(q.size() == 1));
        chk("cap_drop", 32'(cap_drop), 32'(m_drop));
        if (q.size() > 0) chk("rb_o", 32'(rb_o), 32'(q[0]));
        if (cap_drop === 1'b1) ndrop++;
    endtask

    task automatic clr_rx();
        rx = '0;
        nrx = 0;
        nlast = 0;
    endtask

    task automatic load(input logic [7:0] v);
        ce = 1'b1;
        din = v;
        step();
        ce = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        for (int t = 0; t < 60 && rb_valid === 1'b1; t++) begin
            ready = toggle ? (t % 3 == 0) : 1'b1;
            step();
        end
        ready = 1'b1;
    endtask

    initial begin
        m_o = 'x;
        m_drop = 1'b0;
        clr_rx();
        ndrop = 0;

        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("rst_o", 32'(o), 32'hA5);
        chk("rst_valid", 32'(rb_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_drop", 32'(cap_drop), 32'h0);

        load(8'h3C);
        chk("ce_o", 32'(o), 32'h3C);
        clr_rx();
        cap = 1'b1;
        ready = 1'b1;
        step();
        cap = 1'b0;
        chk("cap_latency", 32'(rb_valid), 32'h1);
        drain(1'b0);
        chk("frame_3c", 32'(rx), 32'(FR_3C));
        chk("bits_3c", 32'(nrx), 32'(FL));
        chk("last_3c", 32'(nlast), 32'h1);
        chk("busy_after", 32'(busy), 32'h0);

        sclr = 1'b1; sset = 1'b1; ce = 1'b1; din = 8'h55;
        step();
        chk("sclr_prio", 32'(o), 32'h00);
        sclr = 1'b0;
        step();
        chk("sset_prio", 32'(o), 32'hFF);
        sset = 1'b0; ce = 1'b0;

        load(8'h81);
        clr_rx();
        cap = 1'b1;
        step();
        cap = 1'b0;
        drain(1'b1);
        chk("frame_81", 32'(rx), 32'(FR_81));
        chk("bits_81", 32'(nrx), 32'(FL));

        load(8'hC3);
        ndrop = 0;
        cap = 1'b1;
        ready = 1'b0;
        step();
        step();
        cap = 1'b0;
        ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (rb_last === 1'b1) break;
            step();
        end
        cap = 1'b1;
        step();
        step();
        cap = 1'b0;
        chk("drop_count", 32'(ndrop), 32'h2);
        chk("recap_busy", 32'(busy), 32'h1);
        drain(1'b0);

        load(8'h5A);
        cap = 1'b1;
        step();
        cap = 1'b0;
        step(); step(); step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("abort_valid", 32'(rb_valid), 32'h0);
        chk("abort_o", 32'(o), 32'hA5);
        step();
        chk("abort_quiet", 32'(rb_valid), 32'h0);

        load(8'h07);
        clr_rx();
        cap = 1'b1;
        step();
        cap = 1'b0;
        drain(1'b0);
        chk("frame_07", 32'(rx), 32'(FR_07));
        chk("bits_07", 32'(nrx), 32'(FL));
        chk("last_07", 32'(nlast), 32'h1);

        for (int n = 0; n < 400; n++) begin
            srst  = ($urandom % 60) == 0;
            sclr  = ($urandom % 8) == 0;
            sset  = ($urandom % 8) == 0;
            ce    = ($urandom % 2) == 0;
            din   = 8'($urandom);
            cap   = ($urandom % 4) == 0;
            ready = ($urandom % 2) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
